// File: rtl/score_ssd_driver.sv
// Converts the binary score to five BCD digits by sequential double-dabble and
// time-multiplexes them onto the eight-digit common-anode seven-segment display.
//
//   state | meaning
//   IDLE  | waiting for score to differ from the last converted value
//   SHIFT | 16 add-3/shift-left steps of double-dabble
//   DONE  | commit BCD result to the display register
module score_ssd_driver #(
    parameter int REFRESH_BITS = 17,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        board_clk,
    input  logic        Reset,
    input  logic [15:0] score,
    output logic [7:0]  anode,
    output logic [6:0]  ssd,
    output logic        dp,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state;
    logic [35:0]             shreg;
    logic [35:0]             shreg_adj;
    logic [15:0]             cap_score;
    logic [15:0]             last_score;
    logic [3:0]              shift_cnt;
    logic [19:0]             bcd_disp;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [2:0]              idx;
    logic [3:0]              digit;
    logic                    zero_above;
    logic [6:0]              glyph;

    assign dp  = 1'b1;
    assign idx = refresh_cnt[REFRESH_BITS-1 -: 3];

    always_comb begin
        shreg_adj = shreg;
        for (int n = 0; n < 5; n++) begin
            if (shreg[16 + 4*n +: 4] >= 4'd5)
                shreg_adj[16 + 4*n +: 4] = shreg[16 + 4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cap_score  <= '0;
            last_score <= '0;
            shift_cnt  <= '0;
            bcd_disp   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (score != last_score) begin
                        shreg     <= {20'b0, score};
                        cap_score <= score;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg     <= {shreg_adj[34:0], 1'b0};
                    shift_cnt <= shift_cnt + 4'd1;
                    if (shift_cnt == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    bcd_disp   <= shreg[35:16];
                    last_score <= cap_score;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        digit      = 4'd0;
        zero_above = 1'b0;
        case (idx)
            3'd0: digit = bcd_disp[3:0];
            3'd1: begin
                digit      = bcd_disp[7:4];
                zero_above = (bcd_disp[19:4] == 16'd0);
            end
            3'd2: begin
                digit      = bcd_disp[11:8];
                zero_above = (bcd_disp[19:8] == 12'd0);
            end
            3'd3: begin
                digit      = bcd_disp[15:12];
                zero_above = (bcd_disp[19:12] == 8'd0);
            end
            3'd4: begin
                digit      = bcd_disp[19:16];
                zero_above = (bcd_disp[19:16] == 4'd0);
            end
            default: begin
                digit      = 4'd0;
                zero_above = 1'b0;
            end
        endcase
    end

    always_comb begin
        glyph = 7'b1111111;
        case (digit)
            4'd0: glyph = 7'b0000001;
            4'd1: glyph = 7'b1001111;
            4'd2: glyph = 7'b0010010;
            4'd3: glyph = 7'b0000110;
            4'd4: glyph = 7'b1001100;
            4'd5: glyph = 7'b0100100;
            4'd6: glyph = 7'b0100000;
            4'd7: glyph = 7'b0001111;
            4'd8: glyph = 7'b0000000;
            4'd9: glyph = 7'b0000100;
            default: glyph = 7'b1111111;
        endcase
    end

    // Positions 5..7 and blanked leading zeros keep every anode off.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            refresh_cnt <= '0;
            anode       <= 8'hFF;
            ssd         <= 7'h7F;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if ((idx > 3'd4) || (BLANK_LZ && zero_above)) begin
                anode <= 8'hFF;
                ssd   <= 7'h7F;
            end else begin
                anode <= ~(8'd1 << idx);
                ssd   <= glyph;
            end
        end
    end

endmodule

// File: doc/score_ssd_driver.md
# score_ssd_driver

Reads the 16-bit `score` word written by `game_array` and shows it in decimal on the board's eight-digit common-anode seven-segment display. A sequential double-dabble converter turns the binary score into five BCD digits. A refresh counter then time-multiplexes those digits onto the anodes. The block sits beside the VGA path in the top level, clocked by `board_clk`, and drives `An0..An7`, `Ca..Cg` and `Dp` directly.

## Interface
- `REFRESH_BITS`, default 17: width of the refresh counter. The top 3 bits select the digit position; at 100 MHz each position holds for about 163 µs.
- `BLANK_LZ`, default 1: 1 blanks leading zeros; 0 shows all five digits.
- `board_clk` input, 1 bit: system clock. All state updates on its rising edge.
- `Reset` input, 1 bit: reset, asynchronous, active-high; clock `board_clk`.
- `score` input, 16 bit: binary score from `game_array`. It is not synchronous to any handshake and is sampled only in IDLE.
- `anode` output, 8 bit: active-low anode enables. Bit i drives An_i.
- `ssd` output, 7 bit: active-low segments in the order {Ca,Cb,Cc,Cd,Ce,Cf,Cg}.
- `dp` output, 1 bit: decimal point, always 1 (off).
- `busy` output, 1 bit: 1 while a conversion is in progress (states SHIFT and DONE).

## Operation
- Converter FSM has three states: IDLE, SHIFT, DONE.
- IDLE → SHIFT when `score != last_score`:
  - load a 36-bit shift register with {20'b0, score};
  - latch `score` into `cap_score`;
  - clear the 4-bit `shift_cnt`.
- SHIFT, each cycle:
  - add 3 to every BCD nibble (bits 35:16, five nibbles) that is ≥5;
  - then shift the register left by 1 and increment `shift_cnt`.
- SHIFT → DONE on the cycle where `shift_cnt == 15`, which is the 16th shift.
- DONE → IDLE: set `bcd_disp` = shift register [35:16] and `last_score` = `cap_score`.
- Changes to `score` during SHIFT/DONE are ignored. On return to IDLE the comparison re-runs, so the display always converges to the latest stable score.
- Range is 0..65535. Digit 4 (ten-thousands) is at most 6. There is no overflow case.
- Mux:
  - `refresh_cnt` free-runs and wraps at 2^REFRESH_BITS.
  - `idx` = `refresh_cnt`[REFRESH_BITS-1 : REFRESH_BITS-3].
  - For idx 0..4, drive `anode` with only bit idx low and `ssd` with the glyph for `bcd_disp` digit idx.
  - For idx 5..7, drive `anode` = 8'hFF. The duty cycle is 1/8 per digit.
- Blanking, when `BLANK_LZ`=1: digit i>0 is blanked (`anode` all high) when digits i..4 are all zero. Digit 0 is never blanked, so score 0 shows a single "0".
- Glyphs, active-low abcdefg:
  - 0=0000001
  - 1=1001111
  - 2=0010010
  - 3=0000110
  - 4=1001100
  - 5=0100100
  - 6=0100000
  - 7=0001111
  - 8=0000000
  - 9=0000100
  - Nibble values >9 cannot occur; if they do, show 1111111.

## Timing
- Reset (asynchronous) values:
  - outputs: `anode`=8'hFF, `ssd`=7'h7F, `dp`=1, `busy`=0;
  - state: IDLE, `bcd_disp`=0, `last_score`=0, `refresh_cnt`=0.
- After reset, `score`=0 equals `last_score`, so no conversion starts.
- Conversion latency, measured from edge k where IDLE samples a changed score:
  - edge k: enter SHIFT, `busy`=1 after edge k;
  - edges k+1..k+16: shifts;
  - edge k+17: DONE commits `bcd_disp`, returns to IDLE, `busy`=0.
  - The new digit glyph appears on `ssd` at edge k+18 when its position is active.
- `anode` and `ssd` are registered: one cycle after `idx`/`bcd_disp` changes.
- Back-to-back changes: the earliest re-sample is edge k+18 (the IDLE cycle after DONE).
- Reset mid-conversion: the FSM returns to IDLE, `bcd_disp` returns to 0 and the display blanks. Once Reset is released, a nonzero score starts a new conversion.

## Test plan
- Reset release with `score`=0, REFRESH_BITS=4: `busy` stays 0. Only An0 goes low, during idx=0, with `ssd`=0000001. All anodes are high for idx 1..7.
- `score` 0→1234 at edge k: `busy` high for edges k+1..k+17 and low after edge k+17. Digits 0..3 show glyphs 4,3,2,1. Digit 4 is blanked.
- `score`=65535: `bcd_disp`=6,5,5,3,5 for digits 4..0, and all five anodes are active in turn.
- `score` 100→205 at cycle k+5 during the conversion of 100: display first shows "100". A second conversion then starts at k+18 and the display ends at "205".
- `BLANK_LZ`=0 with `score`=7: display shows 00007 on An4..An0.
- Reset asserted at shift 8 of a 9999 conversion: outputs take their reset values immediately. After release with `score`=9999, 9999 is shown 17 cycles after the sampling edge.
